// File: rtl/ahb_slave_interface.sv
// rtl/ahb_slave_interface.sv - AHB slave front end: address decode, pipeline, error response
//
// Purpose: qualifies AHB address phases for a three-slave APB bridge. It decodes
// the APB slave select, pipelines address/data/direction by accepted phases,
// tracks burst state, and generates the two-cycle AHB ERROR response for
// transfers that cannot be forwarded.
//
// Ports:
//   Hclk, Hreset        clock, synchronous active-high reset
//   Hwrite, Hreadyin    AHB direction and bus HREADY
//   Htrans, Hsize       AHB transfer type and size
//   Haddr, Hwdata       AHB address and write data
//   Prdata              APB read data
//   valid               legal active transfer for the APB controller
//   Haddr1/2, Hwdata1/2 address/write data delayed by 1/2 accepted phases
//   Hwritereg           Hwrite delayed by one accepted phase
//   tempselx            one-hot APB slave select
//   Hrdata              read data back to AHB
//   Hresp, Herr_ready   AHB response and error-path HREADY contribution

module ahb_slave_interface #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLV_SPAN  = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [2:0]  Hsize,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hwdata1,
    output logic [31:0] Hwdata2,
    output logic        Hwritereg,
    output logic [2:0]  tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Herr_ready
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // Region limits carried in 33 bits so a base near the top of the map cannot wrap.
    localparam logic [32:0] LIM0 = {1'b0, BASE_ADDR};
    localparam logic [32:0] LIM1 = LIM0 + {1'b0, SLV_SPAN};
    localparam logic [32:0] LIM2 = LIM1 + {1'b0, SLV_SPAN};
    localparam logic [32:0] LIM3 = LIM2 + {1'b0, SLV_SPAN};

    err_state_t  state_q, state_d;
    logic [31:0] haddr1_q, haddr1_d;
    logic [31:0] haddr2_q, haddr2_d;
    logic [31:0] hwdata1_q, hwdata1_d;
    logic [31:0] hwdata2_q, hwdata2_d;
    logic        hwritereg_q, hwritereg_d;
    logic        burst_q, burst_d;

    logic [32:0] addr_ext;
    logic        active;
    logic        misaligned;
    logic        err_cond;

    // Slave decode
    always_comb begin
        addr_ext = {1'b0, Haddr};
        tempselx = 3'b000;
        if (addr_ext >= LIM0 && addr_ext < LIM1) begin
            tempselx = 3'b001;
        end else if (addr_ext >= LIM1 && addr_ext < LIM2) begin
            tempselx = 3'b010;
        end else if (addr_ext >= LIM2 && addr_ext < LIM3) begin
            tempselx = 3'b100;
        end
    end

    // Transfer qualification
    always_comb begin
        active     = Hreadyin & Htrans[1];
        misaligned = ((Hsize == 3'b001) && Haddr[0]) ||
                     ((Hsize == 3'b010) && (Haddr[1:0] != 2'b00)) ||
                     (Hsize > 3'b010);
        // A SEQ beat is only legal while a burst started by an accepted NONSEQ is open.
        err_cond   = active & ((tempselx == 3'b000) | misaligned |
                               ((Htrans == TR_SEQ) & ~burst_q));
        valid      = active & ~err_cond & (state_q != ST_ERR1);
    end

    // Pipeline and burst tracking next state
    always_comb begin
        haddr1_d    = haddr1_q;
        haddr2_d    = haddr2_q;
        hwdata1_d   = hwdata1_q;
        hwdata2_d   = hwdata2_q;
        hwritereg_d = hwritereg_q;
        burst_d     = burst_q;
        if (Hreadyin) begin
            haddr1_d    = Haddr;
            haddr2_d    = haddr1_q;
            hwdata1_d   = Hwdata;
            hwdata2_d   = hwdata1_q;
            hwritereg_d = Hwrite;
            if ((Htrans == TR_IDLE) || err_cond) begin
                burst_d = 1'b0;
            end else if (valid && (Htrans == TR_NONSEQ)) begin
                burst_d = 1'b1;
            end
        end
    end

    // Error response FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OKAY: if (err_cond) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = err_cond ? ST_ERR1 : ST_OKAY;
            default: state_d = ST_OKAY;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state_q     <= ST_OKAY;
            haddr1_q    <= 32'h0;
            haddr2_q    <= 32'h0;
            hwdata1_q   <= 32'h0;
            hwdata2_q   <= 32'h0;
            hwritereg_q <= 1'b0;
            burst_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            haddr1_q    <= haddr1_d;
            haddr2_q    <= haddr2_d;
            hwdata1_q   <= hwdata1_d;
            hwdata2_q   <= hwdata2_d;
            hwritereg_q <= hwritereg_d;
            burst_q     <= burst_d;
        end
    end

    // Response outputs are forced to OKAY/ready for the whole time reset is held,
    // so an abandoned error sequence never reaches the bus.
    always_comb begin
        Hresp      = (!Hreset && (state_q != ST_OKAY)) ? 2'b01 : 2'b00;
        Herr_ready = Hreset || (state_q != ST_ERR1);
    end

    assign Hrdata    = Prdata;
    assign Haddr1    = haddr1_q;
    assign Haddr2    = haddr2_q;
    assign Hwdata1   = hwdata1_q;
    assign Hwdata2   = hwdata2_q;
    assign Hwritereg = hwritereg_q;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// tb/tb_ahb_slave_interface.sv - directed table-driven bench for ahb_slave_interface

module tb_ahb_slave_interface;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NS   = 2'b10;
    localparam logic [1:0] SQ   = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        valid;
    logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
    logic        hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        herr_ready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ahb_slave_interface dut (
        .Hclk       (clk),
        .Hreset     (rst),
        .Hwrite     (hwrite),
        .Hreadyin   (hreadyin),
        .Htrans     (htrans),
        .Hsize      (hsize),
        .Haddr      (haddr),
        .Hwdata     (hwdata),
        .Prdata     (prdata),
        .valid      (valid),
        .Haddr1     (haddr1),
        .Haddr2     (haddr2),
        .Hwdata1    (hwdata1),
        .Hwdata2    (hwdata2),
        .Hwritereg  (hwritereg),
        .tempselx   (tempselx),
        .Hrdata     (hrdata),
        .Hresp      (hresp),
        .Herr_ready (herr_ready)
    );

    // Inputs for one cycle, and every output expected in that cycle before its rising edge.
    typedef struct {
        logic [1:0]  trans;
        logic        rdy;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_valid;
        logic [2:0]  e_sel;
        logic [1:0]  e_resp;
        logic        e_erdy;
        logic [31:0] e_a1;
        logic [31:0] e_a2;
        logic [31:0] e_wd1;
        logic        e_wr;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] tr, input logic rd, input logic w,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        rst      = r;
        htrans   = tr;
        hreadyin = rd;
        hwrite   = w;
        hsize    = sz;
        haddr    = a;
        hwdata   = d;
    endtask

    initial begin
        vecs[0]  = '{IDLE, 1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 1'b0, 3'b000, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{NS,   1'b1, 1'b1, 3'b010, 32'h8000_0010, 32'hA5A5_0001, 1'b1, 3'b001, 2'b00, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{NS,   1'b1, 1'b0, 3'b010, 32'h8400_0000, 32'h0000_0002, 1'b1, 3'b010, 2'b00, 1'b1, 32'h8000_0010, 32'h0, 32'hA5A5_0001, 1'b1};
        vecs[3]  = '{SQ,   1'b1, 1'b0, 3'b010, 32'h8400_0004, 32'h0000_0003, 1'b1, 3'b010, 2'b00, 1'b1, 32'h8400_0000, 32'h8000_0010, 32'h2, 1'b0};
        vecs[4]  = '{IDLE, 1'b1, 1'b0, 3'b010, 32'h8800_0000, 32'h0000_0004, 1'b0, 3'b100, 2'b00, 1'b1, 32'h8400_0004, 32'h8400_0000, 32'h3, 1'b0};
        vecs[5]  = '{NS,   1'b1, 1'b1, 3'b010, 32'h9000_0000, 32'h0000_0005, 1'b0, 3'b000, 2'b00, 1'b1, 32'h8800_0000, 32'h8400_0004, 32'h4, 1'b0};
        vecs[6]  = '{IDLE, 1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0006, 1'b0, 3'b000, 2'b01, 1'b0, 32'h9000_0000, 32'h8800_0000, 32'h5, 1'b1};
        vecs[7]  = '{IDLE, 1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0000_0007, 1'b0, 3'b001, 2'b01, 1'b1, 32'h9000_0000, 32'h8800_0000, 32'h5, 1'b1};
        vecs[8]  = '{SQ,   1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0000_0008, 1'b0, 3'b001, 2'b00, 1'b1, 32'h8000_0000, 32'h9000_0000, 32'h7, 1'b0};
        vecs[9]  = '{IDLE, 1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0009, 1'b0, 3'b000, 2'b01, 1'b0, 32'h8000_0004, 32'h8000_0000, 32'h8, 1'b0};
        vecs[10] = '{NS,   1'b1, 1'b1, 3'b010, 32'h8800_0002, 32'h0000_000A, 1'b0, 3'b100, 2'b01, 1'b1, 32'h8000_0004, 32'h8000_0000, 32'h8, 1'b0};
        vecs[11] = '{IDLE, 1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_000B, 1'b0, 3'b000, 2'b01, 1'b0, 32'h8800_0002, 32'h8000_0004, 32'hA, 1'b1};
        vecs[12] = '{NS,   1'b1, 1'b0, 3'b010, 32'h8400_0010, 32'h0000_000C, 1'b1, 3'b010, 2'b01, 1'b1, 32'h8800_0002, 32'h8000_0004, 32'hA, 1'b1};
        vecs[13] = '{NS,   1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0000_000D, 1'b0, 3'b001, 2'b00, 1'b1, 32'h8400_0010, 32'h8800_0002, 32'hC, 1'b0};
        vecs[14] = '{NS,   1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0000_000E, 1'b0, 3'b001, 2'b01, 1'b0, 32'h8000_0000, 32'h8400_0010, 32'hD, 1'b0};
        vecs[15] = '{IDLE, 1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_000F, 1'b0, 3'b000, 2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'hE, 1'b0};
        vecs[16] = '{NS,   1'b1, 1'b1, 3'b001, 32'h8BFF_FFFE, 32'h0000_0010, 1'b1, 3'b100, 2'b00, 1'b1, 32'h0, 32'h8000_0000, 32'hF, 1'b0};
        vecs[17] = '{BUSY, 1'b1, 1'b1, 3'b001, 32'h8BFF_FFFE, 32'h0000_0011, 1'b0, 3'b100, 2'b00, 1'b1, 32'h8BFF_FFFE, 32'h0, 32'h10, 1'b1};
        vecs[18] = '{SQ,   1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0000_0012, 1'b1, 3'b001, 2'b00, 1'b1, 32'h8BFF_FFFE, 32'h8BFF_FFFE, 32'h11, 1'b1};
        vecs[19] = '{NS,   1'b1, 1'b0, 3'b001, 32'h7FFF_FFFE, 32'h0000_0013, 1'b0, 3'b000, 2'b00, 1'b1, 32'h8000_0001, 32'h8BFF_FFFE, 32'h12, 1'b0};

        prdata = 32'h0;
        drive(1'b1, IDLE, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(1'b0, vecs[i].trans, vecs[i].rdy, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            prdata = 32'hD000_0000 + 32'(i);
            #1;
            check($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d tempselx", i), {29'b0, tempselx}, {29'b0, vecs[i].e_sel});
            check($sformatf("v%0d Hresp", i), {30'b0, hresp}, {30'b0, vecs[i].e_resp});
            check($sformatf("v%0d Herr_ready", i), {31'b0, herr_ready}, {31'b0, vecs[i].e_erdy});
            check($sformatf("v%0d Haddr1", i), haddr1, vecs[i].e_a1);
            check($sformatf("v%0d Haddr2", i), haddr2, vecs[i].e_a2);
            check($sformatf("v%0d Hwdata1", i), hwdata1, vecs[i].e_wd1);
            check($sformatf("v%0d Hwritereg", i), {31'b0, hwritereg}, {31'b0, vecs[i].e_wr});
            check($sformatf("v%0d Hrdata", i), hrdata, 32'hD000_0000 + 32'(i));
        end

        // Reset while in ERR1 (entered by the last vector): response abandoned, pipeline cleared.
        @(negedge clk);
        drive(1'b1, IDLE, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        check("rst_in_err1 Hresp", {30'b0, hresp}, 32'h0);
        check("rst_in_err1 Herr_ready", {31'b0, herr_ready}, 32'h1);
        @(negedge clk);
        drive(1'b0, IDLE, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        check("post_rst Hresp", {30'b0, hresp}, 32'h0);
        check("post_rst Herr_ready", {31'b0, herr_ready}, 32'h1);
        check("post_rst Haddr1", haddr1, 32'h0);
        check("post_rst Haddr2", haddr2, 32'h0);
        check("post_rst Hwdata1", hwdata1, 32'h0);
        check("post_rst Hwdata2", hwdata2, 32'h0);
        check("post_rst Hwritereg", {31'b0, hwritereg}, 32'h0);

        // Reset must also close any burst: a SEQ straight after it is an error.
        @(negedge clk);
        drive(1'b0, SQ, 1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0);
        #1;
        check("seq_after_rst valid", {31'b0, valid}, 32'h0);
        @(negedge clk);
        drive(1'b0, IDLE, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        #1;
        check("seq_after_rst Hresp", {30'b0, hresp}, 32'h1);
        @(negedge clk);
        drive(1'b0, IDLE, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);

        // Load two phases, then stall three cycles with moving inputs.
        @(negedge clk);
        drive(1'b0, NS, 1'b1, 1'b1, 3'b010, 32'h8000_0020, 32'h1111_1111);
        @(negedge clk);
        drive(1'b0, NS, 1'b1, 1'b1, 3'b010, 32'h8000_0024, 32'h2222_2222);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b0, NS, 1'b0, 1'b0, 3'b010, 32'h8400_0000 + 32'(k * 4), $urandom);
            #1;
            check($sformatf("stall%0d valid", k), {31'b0, valid}, 32'h0);
            check($sformatf("stall%0d Haddr1", k), haddr1, 32'h8000_0024);
            check($sformatf("stall%0d Haddr2", k), haddr2, 32'h8000_0020);
            check($sformatf("stall%0d Hwdata1", k), hwdata1, 32'h2222_2222);
            check($sformatf("stall%0d Hwdata2", k), hwdata2, 32'h1111_1111);
            check($sformatf("stall%0d Hwritereg", k), {31'b0, hwritereg}, 32'h1);
            check($sformatf("stall%0d Hresp", k), {30'b0, hresp}, 32'h0);
        end
        @(negedge clk);
        #1;
        check("stall_end Haddr1", haddr1, 32'h8000_0024);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
